// File: rtl/pipe_accum_sink_if.sv
// pipe_accum_sink_if
//   Bundles the two data-path ports of the accumulator sink:
//   - upstream 4-phase bundled-data channel (req_in / data_in / ack_out)
//   - downstream valid/ready result channel (sum_out / sum_valid / sum_ready)
//   slave  : the sink's view (consumes req/data, produces ack and sums)
//   master : the environment's view (adder upstream + consumer downstream)
interface pipe_accum_sink_if;
    logic        req_in;
    logic [7:0]  data_in;
    logic        ack_out;
    logic [15:0] sum_out;
    logic        sum_valid;
    logic        sum_ready;

    modport slave (
        input  req_in, data_in, sum_ready,
        output ack_out, sum_out, sum_valid
    );

    modport master (
        output req_in, data_in, sum_ready,
        input  ack_out, sum_out, sum_valid
    );
endinterface

// File: rtl/pipe_accum_sink.sv
// pipe_accum_sink
//   Synchronous consumer for the self-timed adder pipeline. The adder's
//   request is brought into the clk domain through a two-flop synchroniser;
//   each accepted word is acknowledged with a 4-phase handshake and summed
//   into a 16-bit accumulator. Every GROUP words the completed sum is
//   presented on a valid/ready port.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport: req_in/data_in/ack_out upstream,
//            sum_out/sum_valid/sum_ready downstream
//   busy   - partial group held or handshake in progress
module pipe_accum_sink #(
    parameter int GROUP = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pipe_accum_sink_if.slave        bus,
    output logic                    busy
);

    localparam logic [8:0] LAST = 9'(GROUP - 1);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state, state_nxt;
    logic        req_meta, req_s;
    logic [15:0] acc;
    logic [8:0]  cnt;
    logic [15:0] sum_q;
    logic        valid_q;
    logic        last_word, stalled, capture, final_cap, consume;

    // Two-flop synchroniser; data_in is deliberately not synchronised since
    // the bundling guarantees it is stable once req_s is seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_meta <= 1'b0;
            req_s    <= 1'b0;
        end else begin
            req_meta <= bus.req_in;
            req_s    <= req_meta;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture) state_nxt = ACK;
            ACK:  if (!req_s)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs and capture decode. A final word may only be taken when
    // the output slot is free or is being drained on this very edge, so the
    // upstream request is simply left pending while the slot is blocked.
    always_comb begin
        last_word   = (cnt == LAST);
        consume     = valid_q && bus.sum_ready;
        stalled     = last_word && valid_q && !bus.sum_ready;
        capture     = (state == IDLE) && req_s && !stalled;
        final_cap   = capture && last_word;
        bus.ack_out = (state == ACK);
        busy        = (cnt != 9'd0) || (state == ACK);
    end

    // Accumulator and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            if (final_cap) begin
                sum_q   <= acc + {8'd0, bus.data_in};
                valid_q <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                if (capture) begin
                    acc <= acc + {8'd0, bus.data_in};
                    cnt <= cnt + 9'd1;
                end
                if (consume) valid_q <= 1'b0;
            end
        end
    end

    assign bus.sum_out   = sum_q;
    assign bus.sum_valid = valid_q;

endmodule

// File: tb/tb_pipe_accum_sink.sv
// tb_pipe_accum_sink
//   Directed + randomised bench for pipe_accum_sink. Three instances cover
//   GROUP=4, GROUP=256 and GROUP=1. Expected sums come from a word-level
//   model (running total per group); handshake ordering is watched by a
//   monitor that flags any ack_out edge not matching req_in's level.
module tb_pipe_accum_sink;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] req = '0;
    logic [2:0] rdy = '0;
    logic [7:0] dat [3];
    logic       rnd_mode = 1'b0;
    logic       rdy_rnd  = 1'b0;

    pipe_accum_sink_if b0();
    pipe_accum_sink_if b1();
    pipe_accum_sink_if b2();

    assign b0.req_in = req[0]; assign b0.data_in = dat[0];
    assign b1.req_in = req[1]; assign b1.data_in = dat[1];
    assign b2.req_in = req[2]; assign b2.data_in = dat[2];
    assign b0.sum_ready = rnd_mode ? rdy_rnd : rdy[0];
    assign b1.sum_ready = rdy[1];
    assign b2.sum_ready = rdy[2];

    logic [2:0]  bsy;
    wire  [2:0]  ack = {b2.ack_out, b1.ack_out, b0.ack_out};
    wire  [2:0]  vld = {b2.sum_valid, b1.sum_valid, b0.sum_valid};
    wire  [2:0]  srd = {b2.sum_ready, b1.sum_ready, b0.sum_ready};
    wire  [15:0] so [3];
    assign so[0] = b0.sum_out;
    assign so[1] = b1.sum_out;
    assign so[2] = b2.sum_out;

    pipe_accum_sink #(.GROUP(4))   u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave), .busy(bsy[0]));
    pipe_accum_sink #(.GROUP(256)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(bsy[1]));
    pipe_accum_sink #(.GROUP(1))   u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave), .busy(bsy[2]));

    int nvec = 0;
    int nerr = 0;
    int tout = 0;

    // ---------------- monitors ----------------
    logic [15:0] gotq [3][$];
    logic [15:0] expq [3][$];
    int          vrise [3];
    int          viol = 0;
    logic [2:0]  ack_prev = '0;
    logic [2:0]  vld_prev = '0;

    always @(posedge clk) rdy_rnd <= 1'($urandom);

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++)
            if (vld[d] === 1'b1 && srd[d] === 1'b1) gotq[d].push_back(so[d]);
    end

    // Strict 4-phase: ack may only move to the level req is currently at.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ack[d] != ack_prev[d] && ack[d] != req[d]) viol++;
            if (vld[d] === 1'b1 && vld_prev[d] === 1'b0) vrise[d]++;
        end
        ack_prev <= ack;
        vld_prev <= vld;
    end

    // ---------------- reference model ----------------
    int m_acc [3];
    int m_n   [3];

    function automatic int grp(int d);
        return (d == 0) ? 4 : (d == 1) ? 256 : 1;
    endfunction

    task automatic model_word(int d, logic [7:0] v);
        m_acc[d] += int'(v);
        m_n[d]++;
        if (m_n[d] == grp(d)) begin
            expq[d].push_back(16'(m_acc[d]));
            m_acc[d] = 0;
            m_n[d]   = 0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_acc[d] = 0;
            m_n[d]   = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] last_got(int d);
        if (gotq[d].size() == 0) return 32'hFFFF_FFFF;
        return 32'(gotq[d][gotq[d].size()-1]);
    endfunction

    task automatic cmp_sums(int d, string tag);
        int n;
        chk({tag, "_count"}, gotq[d].size(), expq[d].size());
        n = (gotq[d].size() < expq[d].size()) ? gotq[d].size() : expq[d].size();
        for (int i = 0; i < n; i++) chk({tag, "_sum"}, 32'(gotq[d][i]), 32'(expq[d][i]));
        gotq[d].delete();
        expq[d].delete();
    endtask

    task automatic settle(int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns posedges elapsed until ack reaches lvl, or -1 on timeout.
    task automatic wait_ack(int d, logic lvl, int budget, output int lat);
        int t0;
        t0  = cyc;
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack[d] === lvl) begin
                lat = cyc - t0;
                return;
            end
        end
    endtask

    function automatic int rnd_phase();
        int p;
        p = int'($urandom_range(1, 8));
        if (p >= 5) p++;
        return p;
    endfunction

    task automatic send(int d, logic [7:0] v, int ph, output int lr, output int lf);
        @(posedge clk); #(ph);
        req[d] = 1'b1;
        dat[d] = v;
        model_word(d, v);
        wait_ack(d, 1'b1, 300, lr);
        @(posedge clk); #(ph);
        req[d] = 1'b0;
        dat[d] = 8'($urandom);
        wait_ack(d, 1'b0, 300, lf);
        if (lr < 0 || lf < 0) tout++;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lr, lf;
        logic [7:0] words [4];
        for (int d = 0; d < 3; d++) begin
            dat[d]   = 8'd0;
            vrise[d] = 0;
        end
        model_reset();

        // reset state
        #23;
        chk("rst_ack",   ack[0],    1'b0);
        chk("rst_valid", vld[0],    1'b0);
        chk("rst_sum",   so[0],     16'd0);
        chk("rst_busy",  bsy[0],    1'b0);
        chk("rst_g1",    {ack[2], vld[2], bsy[2]}, 3'b000);
        @(negedge clk) rst_n = 1'b1;

        // basic group: 1,2,3,4, exact 3-clock handshake latency
        rdy[0] = 1'b1;
        words = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int i = 0; i < 4; i++) begin
            send(0, words[i], 1, lr, lf);
            chk("lat_rise", lr, 3);
            chk("lat_fall", lf, 3);
        end
        settle(3);
        chk("basic_pulses", vrise[0], 1);
        chk("basic_sum", last_got(0), 10);
        chk("basic_idle", bsy[0], 1'b0);
        cmp_sums(0, "basic");

        // maximum values
        for (int i = 0; i < 4; i++) send(0, 8'hFF, rnd_phase(), lr, lf);
        settle(3);
        chk("max_sum", last_got(0), 16'h03FC);
        cmp_sums(0, "max");

        // back-pressure: two groups of 5s with sum_ready low
        rdy[0] = 1'b0;
        for (int i = 0; i < 7; i++) send(0, 8'd5, rnd_phase(), lr, lf);
        settle(2);
        chk("bp_held_valid", vld[0], 1'b1);
        chk("bp_held_sum",   so[0],  16'd20);
        chk("bp_busy",       bsy[0], 1'b1);
        @(posedge clk); #1;
        req[0] = 1'b1;
        dat[0] = 8'd5;
        model_word(0, 8'd5);
        wait_ack(0, 1'b1, 20, lr);
        chk("bp_no_ack", lr, 32'hFFFF_FFFF);
        chk("bp_still_20", so[0], 16'd20);
        rdy[0] = 1'b1;
        wait_ack(0, 1'b1, 4, lr);
        chk("bp_release_lat", lr, 1);
        chk("bp_reload_valid", vld[0], 1'b1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_ack(0, 1'b0, 10, lf);
        chk("bp_release_fall", lf, 3);
        settle(2);
        cmp_sums(0, "bp");

        // mid-group reset
        send(0, 8'd7, rnd_phase(), lr, lf);
        send(0, 8'd9, rnd_phase(), lr, lf);
        settle(1);
        chk("mid_busy_pre", bsy[0], 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {ack[0], vld[0], bsy[0]}, 3'b000);
        chk("mid_rst_sum", so[0], 16'd0);
        model_reset();
        cmp_sums(0, "mid_pre");
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(0, 8'd1, rnd_phase(), lr, lf);
        settle(3);
        chk("mid_sum", last_got(0), 4);
        cmp_sums(0, "mid");

        // GROUP=256 at full scale
        rdy[1] = 1'b1;
        for (int i = 0; i < 256; i++) send(1, 8'hFF, rnd_phase(), lr, lf);
        settle(3);
        chk("g256_sum", last_got(1), 16'hFF00);
        chk("g256_idle", bsy[1], 1'b0);
        cmp_sums(1, "g256");

        // GROUP=1: each word is its own result
        rdy[2] = 1'b1;
        send(2, 8'd3, rnd_phase(), lr, lf);
        settle(2);
        chk("g1_first", last_got(2), 3);
        send(2, 8'd0, rnd_phase(), lr, lf);
        settle(2);
        chk("g1_zero", last_got(2), 0);
        send(2, 8'd200, rnd_phase(), lr, lf);
        settle(2);
        chk("g1_200", last_got(2), 200);
        chk("g1_idle", bsy[2], 1'b0);
        cmp_sums(2, "g1");

        // randomised phases, values and back-pressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 125; i++) send(0, 8'($urandom), rnd_phase(), lr, lf);
        rnd_mode = 1'b0;
        settle(6);
        cmp_sums(0, "rand");
        chk("rand_partial_busy", bsy[0], 1'b1);
        chk("protocol_viol", viol, 0);
        chk("handshake_timeouts", tout, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pipe_accum_sink.md
# pipe_accum_sink

Clocked consumer stage placed directly downstream of the three-operand pipelined adder. It receives the adder's 8-bit result over a 4-phase bundled-data request/acknowledge handshake and synchronises the request into the clock domain. It accumulates a fixed group of results into a 16-bit sum and presents each completed sum on a valid/ready output port. It is the boundary where the self-timed adder pipeline enters synchronous logic.

## Interface
- GROUP, 4, number of input words summed per output result; legal range 1..256
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; release is synchronised by the integrating level
- req_in  input  1  4-phase request from the adder's request output; asynchronous to clk
- data_in  input  8  adder result; bundled with req_in, stable from req_in rise until ack_out rise
- ack_out  output  1  4-phase acknowledge back to the adder's acknowledge input; registered
- sum_out  output  16  completed group sum; held stable while sum_valid=1
- sum_valid  output  1  sum_out holds an unconsumed result
- sum_ready  input  1  downstream accepts sum_out in any cycle with sum_valid=1 and sum_ready=1
- busy  output  1  high when cnt != 0 or the FSM is in ACK (partial group or handshake in progress)

## Operation
- **Synchroniser.** req_in passes through two flops to produce req_s. data_in is never synchronised; bundled-data timing guarantees it is stable when req_s is seen high.
- **Internal state:** acc[15:0], cnt[8:0], FSM state {IDLE, ACK}.
- **FSM IDLE** (ack_out=0):
  - If req_s=1 and not stalled: capture the word, then go to ACK.
  - stalled = (cnt==GROUP-1) and sum_valid and !sum_ready.
  - While stalled, stay in IDLE with ack_out=0; the upstream request stays pending.
- **Word capture** (non-final word, cnt < GROUP-1): acc <= acc + data_in; cnt <= cnt+1.
- **Final word** (cnt==GROUP-1):
  - sum_out <= acc + data_in; sum_valid <= 1.
  - acc <= 0; cnt <= 0.
- **FSM ACK** (ack_out=1): stay while req_s=1. On req_s=0, go to IDLE; ack_out falls.
- **Output port:**
  - sum_valid clears on a cycle with sum_valid&&sum_ready, unless a final-word capture occurs in the same cycle. In that case the new sum loads and sum_valid stays 1.
  - sum_out is unchanged while sum_valid=1 and no handshake has occurred.
- **Arithmetic:** unsigned and zero-extended; no overflow is possible, since 256×255 = 65280 < 2^16.
- **GROUP=1:** every word produces a result directly; acc stays 0.
- **Reset (async, any time):**
  - ack_out=0, sum_valid=0, sum_out=0, busy=0.
  - acc=0, cnt=0, state=IDLE, synchroniser flops=0.
  - A partial group is discarded.
  - If req_in is still high after reset, it is treated as a new request once synchronised. The upstream stage shares the reset, so this does not occur in a correctly reset system.

## Timing
- **Request to acknowledge:** req_in rise at edge k → req_s high after edge k+2 → capture at edge k+3 → ack_out=1 after edge k+3. Latency is 3 clocks, plus up to 1 clock of asynchronous sampling uncertainty.
- **Release:** req_in fall → ack_out fall after 3 clocks, by the same path.
- **Result timing:** sum_valid rises in the same cycle ack_out rises for the final word of a group.
- **Throughput:** a minimum of about 6 clocks per word, plus upstream response time.
- **Back-pressure:** a full output stall holds ack_out low indefinitely. After sum_ready is seen, capture occurs on the same edge as the consuming handshake.
- **Protocol:** ack_out never rises while req_s=0 and never falls while req_s=1 (strict 4-phase).

## Test plan
- **Basic group:** GROUP=4, words 1,2,3,4 with sum_ready=1.
  - Expect sum_out=10 and a single sum_valid pulse.
  - Expect ack_out rising 3 clocks after each req_in rise and falling 3 clocks after each req_in fall.
- **Maximum values:** GROUP=4, four words of 8'hFF.
  - Expect sum_out=16'h03FC.
  - With GROUP=256 and 256×8'hFF, expect sum_out=16'hFF00.
- **Back-pressure:** sum_ready=0, two groups of {5,5,5,5}.
  - After the first sum (20) is held, the 8th word's req_in receives no ack_out.
  - Raise sum_ready: the first 20 is consumed, the second 20 loads on the same edge, then ack_out rises.
- **Mid-group reset:** words 7,9, then rst_n pulsed low.
  - All outputs go to 0 immediately.
  - Then words 1,1,1,1 → sum_out=4, not 20.
- **GROUP=1:** words 3,0,200 → sum_valid results 3, 0, 200 in order, with sum_ready=1.
- **Protocol check:** randomised req_in phase relative to clk, 125 words.
  - No ack_out transition violates 4-phase ordering.
  - Every GROUP-word sum matches a reference model.
